xor_req_driver: RTL and testbench

Initiator-side companion to the delayed XOR unit: accepts 2-bit operand pairs on an upstream valid/ready stream, buffers them, and drives the unit's `wr_en`/`din` write port one transaction at a time. Waits for the unit's `rd_en` acknowledge, samples `dout` after a fixed result latency, and returns the result on a downstream valid/ready stream. Sits between the operand producer and the delayed XOR unit; also serves as the reusable driver in block-level benches.

---
 rtl/xor_req_driver_pkg.sv | 23 ++
 rtl/xor_req_fifo.sv | 48 ++++
 rtl/xor_req_driver.sv | 184 ++++++++++++++++++
 tb/tb_xor_req_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_req_driver_pkg.sv
// rtl/xor_req_driver_pkg.sv - shared types and constants for the XOR request driver
//
// Contents:
//   state_t   - driver FSM states
//   OP_W      - operand / result width (2 bits)
//   to_cnt_w  - width of a counter that must hold values 0..timeout
package xor_req_driver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        CAPTURE,
        RESULT
    } state_t;

    localparam int OP_W = 2;

    function automatic int to_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/xor_req_fifo.sv
// rtl/xor_req_fifo.sv - synchronous operand FIFO for the XOR request driver
//
// Parameters: DEPTH (entries, power of two >= 2), WIDTH (entry width)
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   push, push_data     - write strobe and data; caller must not push when full
//   pop, pop_data       - read strobe; pop_data shows the head entry (valid when !empty)
//   full, empty         - occupancy flags
module xor_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/xor_req_driver.sv
// rtl/xor_req_driver.sv - buffers operand pairs and drives the delayed XOR unit one op at a time
//
// Parameters: DEPTH (operand FIFO entries), RESULT_LAT (cycles after rd_en to sample dout),
//             TIMEOUT (cycles allowed in WAIT_ACK before aborting)
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   s_valid, s_ready, s_data  - upstream operand stream (bit0 = a, bit1 = b)
//   wr_en, din                - write port to the XOR unit
//   rd_en, dout               - acknowledge and result from the XOR unit
//   m_valid, m_ready, m_data  - downstream result stream
//   m_err                     - result qualifier, 1 = aborted on timeout
//   busy                      - transaction in progress or operands queued
// Optional build macro XOR_REQ_DRIVER_CHECK_EN adds chk_fail (sticky) and chk_count
// (saturating) which flag captured results that differ from {1'b0, a^b}.
module xor_req_driver
    import xor_req_driver_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 1,
    parameter int TIMEOUT    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [OP_W-1:0] s_data,
    output logic            wr_en,
    output logic [OP_W-1:0] din,
    input  logic            rd_en,
    input  logic [OP_W-1:0] dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [OP_W-1:0] m_data,
    output logic            m_err,
    output logic            busy
`ifdef XOR_REQ_DRIVER_CHECK_EN
    ,
    output logic            chk_fail,
    output logic [7:0]      chk_count
`endif
);

    localparam int TO_W = to_cnt_w(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [OP_W-1:0] fifo_rdata;
    logic            push;
    logic            pop;
    logic            clr_to;
    logic            inc_to;
    logic            load_lat;
    logic            dec_lat;
    logic            cap_ok;
    logic            cap_to;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      lat_cnt;
    logic [OP_W-1:0] din_q;
    logic [OP_W-1:0] m_data_q;
    logic            m_err_q;

    assign push = s_valid && !fifo_full;

    xor_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        clr_to    = 1'b0;
        inc_to    = 1'b0;
        load_lat  = 1'b0;
        dec_lat   = 1'b0;
        cap_ok    = 1'b0;
        cap_to    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !m_valid) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                clr_to    = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rd_en) begin
                    if (RESULT_LAT == 0) begin
                        cap_ok    = 1'b1;
                        state_nxt = RESULT;
                    end else begin
                        load_lat  = 1'b1;
                        state_nxt = CAPTURE;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle spent waiting.
                    cap_to    = 1'b1;
                    state_nxt = RESULT;
                end else begin
                    inc_to = 1'b1;
                end
            end
            CAPTURE: begin
                // lat_cnt holds the cycles remaining until dout is valid, including this one.
                if (lat_cnt <= 3'd1) begin
                    cap_ok    = 1'b1;
                    state_nxt = RESULT;
                end else begin
                    dec_lat = 1'b1;
                end
            end
            RESULT: begin
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q    <= '0;
            to_cnt   <= '0;
            lat_cnt  <= '0;
            m_data_q <= '0;
            m_err_q  <= 1'b0;
        end else begin
            if (pop)      din_q   <= fifo_rdata;
            if (clr_to)   to_cnt  <= '0;
            if (inc_to)   to_cnt  <= to_cnt + TO_W'(1);
            if (load_lat) lat_cnt <= 3'(RESULT_LAT);
            if (dec_lat)  lat_cnt <= lat_cnt - 3'd1;
            if (cap_ok) begin
                m_data_q <= dout;
                m_err_q  <= 1'b0;
            end
            if (cap_to) begin
                m_data_q <= '0;
                m_err_q  <= 1'b1;
            end
        end
    end

`ifdef XOR_REQ_DRIVER_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_fail  <= 1'b0;
            chk_count <= '0;
        end else if (cap_ok && (dout != {1'b0, din_q[0] ^ din_q[1]})) begin
            chk_fail <= 1'b1;
            if (chk_count != 8'hFF) chk_count <= chk_count + 8'd1;
        end
    end
`else
    // No result checker in this build.
`endif

    assign s_ready = !fifo_full;
    assign wr_en   = (state == ISSUE);
    assign din     = din_q;
    assign m_valid = (state == RESULT);
    assign m_data  = m_data_q;
    assign m_err   = m_err_q;
    assign busy    = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_xor_req_driver.sv
// tb/tb_xor_req_driver.sv - directed self-checking bench for xor_req_driver
module tb_xor_req_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] s_data = 2'b00;
    logic       wr_en;
    logic [1:0] din;
    logic       rd_en = 1'b0;
    logic [1:0] dout = 2'b00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [1:0] m_data;
    logic       m_err;
    logic       busy;
`ifdef XOR_REQ_DRIVER_CHECK_EN
    logic       chk_fail;
    logic [7:0] chk_count;
`endif

    always #5 clk = ~clk;

    xor_req_driver #(
        .DEPTH      (4),
        .RESULT_LAT (1),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_err     (m_err),
        .busy      (busy)
`ifdef XOR_REQ_DRIVER_CHECK_EN
        ,
        .chk_fail  (chk_fail),
        .chk_count (chk_count)
`endif
    );

    // Delayed XOR unit: rd_en one cycle after wr_en, dout one cycle after rd_en.
    logic       ack_en  = 1'b1;
    logic       corrupt = 1'b0;
    logic [1:0] op_q    = 2'b00;
    always @(posedge clk) begin
        rd_en <= wr_en & ack_en;
        op_q  <= din;
        dout  <= rd_en ? (corrupt ? 2'b00 : {1'b0, op_q[0] ^ op_q[1]}) : 2'b00;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Flags any wr_en issued while a previous result is still un-handshaken.
    int   viol  = 0;
    logic outst = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            outst = 1'b0;
        end else begin
            if (wr_en && outst) viol++;
            if (wr_en) outst = 1'b1;
            if (m_valid && m_ready) outst = 1'b0;
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 40 && !s_ready; i++) @(negedge clk);
        if (!s_ready) begin
            total++;
            failed++;
            $error("FAIL push_wait: observed s_ready=0 expected 1 within 40 cycles");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic get_result(input int budget, output logic [1:0] d, output logic e,
                              output int waited, output int at_cyc);
        waited = 0;
        while (!m_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!m_valid) begin
            total++;
            failed++;
            $error("FAIL result_wait: observed m_valid=0 expected 1 within %0d cycles", budget);
        end
        d      = m_data;
        e      = m_err;
        at_cyc = cyc;
        if (m_ready) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        logic [1:0] d;
        logic       e;
        int         w;
        int         t;
        int         t_prev;
        logic [1:0] exp_s [4];
        logic [1:0] exp_f [5];

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_din", din, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_err", m_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single op 01: push accepted cycle 0, wr_en cycle 2, m_valid cycle 5
        m_ready = 1'b1;
        push(2'b01);
        check("single_busy", busy, 1);
        check("single_wr_en_c1", wr_en, 0);
        @(negedge clk);
        check("single_wr_en_c2", wr_en, 1);
        check("single_din", din, 2'b01);
        @(negedge clk);
        check("single_wr_en_c3", wr_en, 0);
        get_result(20, d, e, w, t);
        check("single_latency", w, 2);
        check("single_m_data", d, 2'b01);
        check("single_m_err", e, 0);
        check("single_idle_m_valid", m_valid, 0);
        check("single_idle_busy", busy, 0);

        // Stream 00,11,10,01 -> 0,0,1,1, one result per 5 cycles
        exp_s = '{2'b00, 2'b00, 2'b01, 2'b01};
        push(2'b00);
        push(2'b11);
        push(2'b10);
        push(2'b01);
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            get_result(30, d, e, w, t);
            check($sformatf("stream_data_%0d", k), d, exp_s[k]);
            check($sformatf("stream_err_%0d", k), e, 0);
            if (k > 0) check($sformatf("stream_period_%0d", k), t - t_prev, 5);
            t_prev = t;
        end

        // Fill: 5 pushes with m_ready=0 -> one in flight plus 4 queued, FIFO full
        m_ready = 1'b0;
        exp_f = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        push(2'b01);
        push(2'b00);
        push(2'b11);
        push(2'b10);
        push(2'b01);
        check("fill_s_ready", s_ready, 0);
        check("fill_busy", busy, 1);
        s_valid = 1'b1;
        s_data  = 2'b11;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("fill_refused_s_ready", s_ready, 0);
        check("fill_hold_m_valid", m_valid, 1);
        check("fill_hold_m_data", m_data, 2'b01);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            get_result(30, d, e, w, t);
            check($sformatf("fill_data_%0d", k), d, exp_f[k]);
        end
        check("fill_drained_busy", busy, 0);
        check("fill_drained_s_ready", s_ready, 1);

        // Timeout: no rd_en -> m_valid 8 cycles in WAIT_ACK later with m_err=1
        ack_en = 1'b0;
        push(2'b10);
        get_result(40, d, e, w, t);
        check("timeout_latency", w, 10);
        check("timeout_m_data", d, 2'b00);
        check("timeout_m_err", e, 1);
        ack_en = 1'b1;
        push(2'b01);
        get_result(20, d, e, w, t);
        check("post_timeout_latency", w, 4);
        check("post_timeout_m_data", d, 2'b01);
        check("post_timeout_m_err", e, 0);

        // Reset during CAPTURE: outputs cleared asynchronously, op lost
        push(2'b10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cap_m_valid", m_valid, 0);
        check("rst_cap_m_data", m_data, 0);
        check("rst_cap_m_err", m_err, 0);
        check("rst_cap_busy", busy, 0);
        check("rst_cap_din", din, 0);
        check("rst_cap_s_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("rst_cap_lost", m_valid, 0);

        // Reset during ISSUE: wr_en drops immediately
        push(2'b11);
        @(negedge clk);
        check("rst_issue_pre_wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        check("rst_issue_wr_en", wr_en, 0);
        check("rst_issue_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        push(2'b10);
        get_result(20, d, e, w, t);
        check("post_rst_m_data", d, 2'b01);
        check("post_rst_m_err", e, 0);
        check("post_rst_latency", w, 4);

`ifdef XOR_REQ_DRIVER_CHECK_EN
        check("chk_init_fail", chk_fail, 0);
        check("chk_init_count", chk_count, 0);
        corrupt = 1'b1;
        push(2'b01);
        get_result(20, d, e, w, t);
        corrupt = 1'b0;
        check("chk_bad_m_data", d, 2'b00);
        check("chk_bad_fail", chk_fail, 1);
        check("chk_bad_count", chk_count, 1);
        push(2'b10);
        get_result(20, d, e, w, t);
        check("chk_good_m_data", d, 2'b01);
        check("chk_sticky_fail", chk_fail, 1);
        check("chk_sticky_count", chk_count, 1);
`endif

        for (int i = 0; i < 3; i++) @(negedge clk);
        check("no_overlap_wr_en", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
